// File: rtl/paddle_ctrl_pkg.sv
// Shared pong constants, paddle FSM encoding
// and paddle travel limits.
package paddle_ctrl_pkg;

  localparam int SCR_W     = 32;
  localparam int SCR_H     = 20;
  localparam int PADDLE_H  = 6;
  localparam int BALL_W    = 1;
  localparam int BALL_H    = 1;
  localparam int MAX_SCORE = 9;

  typedef enum logic [1:0] {
    PS_IDLE = 2'd0,
    PS_UP   = 2'd1,
    PS_DN   = 2'd2
  } pad_st_t;

  function automatic logic [10:0] pad_min_f();
    return 11'd1;
  endfunction

  function automatic logic [10:0] pad_max_f(
    input int h,
    input int ph
  );
    return 11'(h - ph);
  endfunction

  function automatic logic [10:0] pad_mid_f(
    input int h,
    input int ph
  );
    return 11'((h - ph) >> 1);
  endfunction

  localparam logic [10:0] PAD_MIN = pad_min_f();
  localparam logic [10:0] PAD_MAX = pad_max_f(SCR_H, PADDLE_H);
  localparam logic [10:0] PAD_MID = pad_mid_f(SCR_H, PADDLE_H);

endpackage

// File: rtl/paddle_ctrl_if.sv
// Player buttons in, clean levels, serve pulses
// and paddle positions out.
interface paddle_ctrl_if;

  logic        RAW_A_UP;
  logic        RAW_A_DOWN;
  logic        RAW_A_SERVE;
  logic        RAW_B_UP;
  logic        RAW_B_DOWN;
  logic        RAW_B_SERVE;
  logic        FREEZE;
  logic        RECENTER;
  logic        A_UP;
  logic        A_DOWN;
  logic        B_UP;
  logic        B_DOWN;
  logic        BUTTON_A;
  logic        BUTTON_B;
  logic [10:0] L_PADDLE_POSITION;
  logic [10:0] R_PADDLE_POSITION;

  modport master (
    output RAW_A_UP, RAW_A_DOWN, RAW_A_SERVE,
    output RAW_B_UP, RAW_B_DOWN, RAW_B_SERVE,
    output FREEZE, RECENTER,
    input  A_UP, A_DOWN, B_UP, B_DOWN,
    input  BUTTON_A, BUTTON_B,
    input  L_PADDLE_POSITION, R_PADDLE_POSITION
  );

  modport slave (
    input  RAW_A_UP, RAW_A_DOWN, RAW_A_SERVE,
    input  RAW_B_UP, RAW_B_DOWN, RAW_B_SERVE,
    input  FREEZE, RECENTER,
    output A_UP, A_DOWN, B_UP, B_DOWN,
    output BUTTON_A, BUTTON_B,
    output L_PADDLE_POSITION, R_PADDLE_POSITION
  );

endinterface

// File: rtl/paddle_ctrl_btn_debounce.sv
// One button: 2-FF sync, stability debounce,
// and a rise pulse aligned with the level edge.
module btn_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic RAW,
  output logic LEVEL,
  output logic RISE
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_lvl;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  // bring the async button into the clock domain
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= RAW;
      r_s2 <= r_s1;
    end
  end

  // accept a change only after CMAX+1 stable cycles
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt  <= '0;
      r_lvl  <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      if (r_s2 == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == CMAX) begin
        r_cnt  <= '0;
        r_lvl  <= r_s2;
        r_rise <= r_s2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign LEVEL = r_lvl;
  assign RISE  = r_rise;

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle front end: six debounced buttons,
// tick divider and two clamped paddle integrators.
module paddle_ctrl
  import paddle_ctrl_pkg::*;
#(
  parameter int SCR_H      = paddle_ctrl_pkg::SCR_H,
  parameter int PADDLE_H   = paddle_ctrl_pkg::PADDLE_H,
  parameter int DEB_CYCLES = 4,
  parameter int MOVE_DIV   = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  paddle_ctrl_if.slave bus
);

  localparam int TW = $clog2(MOVE_DIV);
  localparam logic [TW-1:0] TMAX = TW'(MOVE_DIV - 1);
  localparam logic [10:0] P_MIN = pad_min_f();
  localparam logic [10:0] P_MAX = pad_max_f(SCR_H, PADDLE_H);
  localparam logic [10:0] P_MID = pad_mid_f(SCR_H, PADDLE_H);

  logic [5:0]    w_raw;
  logic [5:0]    w_lvl;
  logic [5:0]    w_rise;
  logic [1:0]    w_up;
  logic [1:0]    w_dn;
  logic [1:0]    w_mv_up;
  logic [1:0]    w_mv_dn;
  logic          w_tick;
  logic [TW-1:0] r_tick_cnt;
  pad_st_t       r_st  [2];
  pad_st_t       w_nst [2];
  logic [10:0]   r_pos [2];

  assign w_raw = {bus.RAW_B_SERVE, bus.RAW_B_DOWN,
                  bus.RAW_B_UP,    bus.RAW_A_SERVE,
                  bus.RAW_A_DOWN,  bus.RAW_A_UP};

  for (genvar g = 0; g < 6; g++) begin : g_deb
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .CLK  (CLK),
      .RST_N(RST_N),
      .RAW  (w_raw[g]),
      .LEVEL(w_lvl[g]),
      .RISE (w_rise[g])
    );
  end

  assign w_up = {w_lvl[3], w_lvl[0]};
  assign w_dn = {w_lvl[4], w_lvl[1]};

  // free-running movement divider
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_tick_cnt <= '0;
    else if (r_tick_cnt == TMAX) r_tick_cnt <= '0;
    else r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  assign w_tick = (r_tick_cnt == TMAX);

  // paddle FSM state registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_st[0] <= PS_IDLE;
      r_st[1] <= PS_IDLE;
    end else begin
      r_st[0] <= w_nst[0];
      r_st[1] <= w_nst[1];
    end
  end

  // direction from debounced levels; conflict idles
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_nst[i] = PS_IDLE;
      unique case (1'b1)
        w_up[i] & ~w_dn[i]: w_nst[i] = PS_UP;
        w_dn[i] & ~w_up[i]: w_nst[i] = PS_DN;
        default:            w_nst[i] = PS_IDLE;
      endcase
    end
  end

  // decode state to move requests
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_mv_up[i] = (r_st[i] == PS_UP);
      w_mv_dn[i] = (r_st[i] == PS_DN);
    end
  end

  // integrate on tick; recenter beats freeze
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pos[0] <= P_MID;
      r_pos[1] <= P_MID;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (bus.RECENTER) begin
          r_pos[i] <= P_MID;
        end else if (!bus.FREEZE && w_tick) begin
          if (w_mv_up[i] && r_pos[i] > P_MIN)
            r_pos[i] <= r_pos[i] - 11'd1;
          else if (w_mv_dn[i] && r_pos[i] < P_MAX)
            r_pos[i] <= r_pos[i] + 11'd1;
        end
      end
    end
  end

  assign bus.A_UP     = w_lvl[0];
  assign bus.A_DOWN   = w_lvl[1];
  assign bus.B_UP     = w_lvl[3];
  assign bus.B_DOWN   = w_lvl[4];
  assign bus.BUTTON_A = w_rise[2];
  assign bus.BUTTON_B = w_rise[5];

  assign bus.L_PADDLE_POSITION = r_pos[0];
  assign bus.R_PADDLE_POSITION = r_pos[1];

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl: debounce,
// serve pulse, move/clamp, freeze, recenter.
module tb_paddle_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   ncyc;

  paddle_ctrl_if bus ();

  paddle_ctrl u_dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // clocks since reset release; ticks end at multiples of 8
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ncyc <= 0;
    else ncyc <= ncyc + 1;
  end

  task automatic chk(
    input string       tag,
    input logic [10:0] got,
    input logic [10:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_to(input int tgt);
    int g;
    g = 0;
    while (ncyc < tgt && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (ncyc != tgt) chk("wait_to", 11'(ncyc), 11'(tgt));
  endtask

  task automatic set_raw(input logic [5:0] v);
    {bus.RAW_B_SERVE, bus.RAW_B_DOWN, bus.RAW_B_UP,
     bus.RAW_A_SERVE, bus.RAW_A_DOWN, bus.RAW_A_UP} = v;
  endtask

  function automatic logic [10:0] outs();
    return {5'd0, bus.A_UP, bus.A_DOWN, bus.B_UP,
            bus.B_DOWN, bus.BUTTON_A, bus.BUTTON_B};
  endfunction

  initial begin
    int hi;
    int first;
    set_raw(6'b0);
    bus.FREEZE   = 1'b0;
    bus.RECENTER = 1'b0;
    step(3);
    rst_n = 1'b1;
    chk("rst_L", bus.L_PADDLE_POSITION, 11'd7);
    chk("rst_R", bus.R_PADDLE_POSITION, 11'd7);
    chk("rst_out", outs(), 11'd0);

    // 3-cycle glitch ignored
    bus.RAW_A_UP = 1'b1;
    step(3);
    bus.RAW_A_UP = 1'b0;
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (bus.A_UP) hi++;
    end
    chk("glitch", 11'(hi), 11'd0);

    // clean press: level exactly 6 clocks later
    bus.RAW_A_UP = 1'b1;
    step(5);
    chk("deb_pre", 11'(bus.A_UP), 11'd0);
    step(1);
    chk("deb_edge", 11'(bus.A_UP), 11'd1);
    bus.RAW_A_UP = 1'b0;
    step(10);

    // serve held 50 clocks -> one pulse at clock 6
    bus.RAW_B_SERVE = 1'b1;
    hi = 0;
    first = 0;
    for (int i = 1; i <= 50; i++) begin
      step(1);
      if (bus.BUTTON_B) begin
        hi++;
        if (first == 0) first = i;
      end
    end
    chk("srv_cnt", 11'(hi), 11'd1);
    chk("srv_lat", 11'(first), 11'd6);
    chk("srv_lvl", 11'(bus.BUTTON_B), 11'd0);
    bus.RAW_B_SERVE = 1'b0;
    step(10);

    // async reset mid-run with all buttons held
    set_raw(6'b111111);
    step(10);
    chk("held_lvl", outs(), 11'b111100);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_L", bus.L_PADDLE_POSITION, 11'd7);
    chk("arst_R", bus.R_PADDLE_POSITION, 11'd7);
    chk("arst_out", outs(), 11'd0);
    set_raw(6'b0);
    step(2);

    // hold A up and B down from release
    rst_n = 1'b1;
    bus.RAW_A_UP   = 1'b1;
    bus.RAW_B_DOWN = 1'b1;
    wait_to(7);
    chk("tick_L7", bus.L_PADDLE_POSITION, 11'd7);
    for (int k = 1; k <= 7; k++) begin
      wait_to(8 * k);
      chk("mv_L", bus.L_PADDLE_POSITION,
          (k < 6) ? 11'(7 - k) : 11'd1);
      chk("mv_R", bus.R_PADDLE_POSITION, 11'(7 + k));
    end
    wait_to(72);
    chk("clamp_L", bus.L_PADDLE_POSITION, 11'd1);
    chk("clamp_R", bus.R_PADDLE_POSITION, 11'd14);

    // A both held; B up held under freeze
    bus.RAW_A_DOWN = 1'b1;
    bus.RAW_B_DOWN = 1'b0;
    bus.RAW_B_UP   = 1'b1;
    bus.FREEZE     = 1'b1;
    wait_to(160);
    chk("conf_L", bus.L_PADDLE_POSITION, 11'd1);
    chk("conf_lv", {9'd0, bus.A_UP, bus.A_DOWN}, 11'd3);
    chk("frz_R", bus.R_PADDLE_POSITION, 11'd14);
    chk("frz_BUP", 11'(bus.B_UP), 11'd1);
    bus.FREEZE = 1'b0;
    wait_to(168);
    chk("unfrz_R", bus.R_PADDLE_POSITION, 11'd13);

    // A down only; B idle
    bus.RAW_A_UP = 1'b0;
    bus.RAW_B_UP = 1'b0;
    wait_to(176);
    chk("dn_L", bus.L_PADDLE_POSITION, 11'd2);
    chk("idle_R", bus.R_PADDLE_POSITION, 11'd13);
    wait_to(256);
    chk("dn_L12", bus.L_PADDLE_POSITION, 11'd12);

    // recenter on the tick cycle beats the move
    wait_to(263);
    bus.RECENTER = 1'b1;
    step(1);
    bus.RECENTER = 1'b0;
    chk("rc_L", bus.L_PADDLE_POSITION, 11'd7);
    chk("rc_R", bus.R_PADDLE_POSITION, 11'd7);
    wait_to(271);
    chk("rc_hold", bus.L_PADDLE_POSITION, 11'd7);
    wait_to(272);
    chk("rc_next", bus.L_PADDLE_POSITION, 11'd8);
    chk("rc_R2", bus.R_PADDLE_POSITION, 11'd7);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
